sum_accumulator: RTL and testbench
==================================

// Module: sum_accumulator
// PURPOSE
//  - Downstream consumer of the registered adder-tree output (the 6-bit sum of four 4-bit operands).
//  - Accumulates N accepted samples into one block total.
//  - Presents the total on a valid/ready output handshake.
//  - The upstream tree has no backpressure, so samples that cannot be accepted are dropped and flagged.
// PARAMETERS
//  W      6   input sample width (unsigned)
//  N      4   samples per block; N >= 2 (N a power of two when ACCUM_AVERAGE_EN is defined)
//  ACC_W  W+$clog2(N)   accumulator/output width; derived localparam, never overridden
// PORTS
//  clk        in   1      single clock, rising edge
//  rst        in   1      asynchronous, active-high reset
//  clear      in   1      synchronous block abort; clears overrun
//  in_valid   in   1      in_data valid this cycle
//  in_data    in   W      sample from adder tree
//  in_ready   out  1      sample accepted when in_valid && in_ready
//  out_valid  out  1      out_data holds a completed block total
//  out_ready  in   1      consumer takes out_data when out_valid && out_ready
//  out_data   out  ACC_W  block total (registered)
//  overrun    out  1      sticky: a valid sample was dropped
// BEHAVIOUR
//  - Reset (async, rst=1): state=ACCUM, acc=0, cnt=0, out_valid=0, out_data=0, overrun=0.
//    Reset applies immediately, including mid-block.
//  - States: ACCUM (collecting samples) and HOLD (total waiting for the consumer).
//  - in_ready = (state==ACCUM) || out_ready. Combinational; no dependency on in_valid.
//  - ACCUM, accepted sample with cnt<N-1: acc+=in_data; cnt++.
//  - ACCUM, accepted sample with cnt==N-1:
//    - out_data<=acc+in_data; out_valid<=1; acc<=0; cnt<=0; go to HOLD.
//    - Latency: out_valid is high the cycle after the N-th accepted sample.
//  - ACCUM, no sample accepted: all registers hold; gaps between samples are legal.
//  - HOLD, out_ready=0: out_data and out_valid hold stable.
//  - HOLD, out_ready=1 (handshake):
//    - out_valid<=0; go to ACCUM.
//    - A simultaneous accepted sample becomes sample 1 of the next block (acc<=in_data, cnt<=1).
//  - Drop: in_valid && !in_ready -> sample discarded; overrun<=1 (sticky).
//  - clear=1 has priority over every other event:
//    - acc=0, cnt=0, out_valid=0, overrun=0, state=ACCUM.
//    - The in_data presented that cycle is ignored.
//    - out_data keeps its last value.
//  - Arithmetic is unsigned. ACC_W bits hold N*(2^W-1) exactly, so no saturation or wrap is possible.
//  - cnt is $clog2(N) bits wide and never exceeds N-1.
// CONFIGURATION
//  - ACCUM_AVERAGE_EN defined:
//    - Adds output port out_avg [W-1:0] = block total >> $clog2(N) (truncating).
//    - out_avg is registered alongside out_data with identical timing; reset value 0.
//    - Elaboration error if N is not a power of two.
//  - ACCUM_AVERAGE_EN undefined: no out_avg port and no averaging logic; all other behaviour identical.
// STRUCTURE
//  - Package accum_pkg holds:
//    - state encodings ACCUM=1'b0, HOLD=1'b1
//    - a clog2 constant function shared with the adder-tree instances
//  - Sub-module sample_counter:
//    - mod-N counter with inc/clr inputs and a last (cnt==N-1) output.
//    - Instantiated once.
//  - FSM, accumulator and output registers stay in this module.
// TESTING (W=6, N=4 unless noted)
//  1. rst pulsed mid-cycle, no clk edge -> out_valid=0, out_data=0, overrun=0, in_ready=1 immediately.
//  2. Samples 10,20,30,40 on consecutive cycles with out_ready=1 -> out_data=100 and out_valid high for exactly one cycle, one cycle after 40.
//  3. Four samples of 63 with random gaps -> out_data=252 (8 bits, no wrap).
//  4. Backpressure and drop sequence:
//     - Send 10,20,30,40 and hold out_ready=0; then send sample 7 -> dropped, overrun=1, out_data stays 100.
//     - Then assert out_ready=1 with in_valid=1, in_data=5 -> 5 accepted as the first sample of the next block.
//  5. Abort and restart:
//     - Send 2 samples, then clear=1 with in_valid=1 -> partial block and the cleared-cycle sample discarded, overrun=0.
//     - Then send 1,2,3,4 -> out_data=10.
//  6. With ACCUM_AVERAGE_EN: 10,20,30,40 -> out_data=100, out_avg=25; with 1,1,1,2 -> out_avg=1 (truncated).

Source files
------------

// File: rtl/accum_pkg.sv
// Shared definitions for the sum accumulator and the adder-tree instances:
// FSM state encoding and a constant clog2 helper usable in parameter math.
package accum_pkg;

    typedef enum logic {
        ACCUM = 1'b0,   // collecting samples of the current block
        HOLD  = 1'b1    // completed total waiting for the consumer
    } state_e;

    // Ceiling log2 for elaboration-time width calculations; clog2(1) = 0.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        while ((64'd1 << r) < 64'(n)) begin
            r++;
        end
        return r;
    endfunction

endpackage : accum_pkg

// File: rtl/sample_counter.sv
// Mod-N sample counter: counts accepted samples within a block, wraps to
// zero after the N-th, and flags the final position with last_o.
module sample_counter
    import accum_pkg::*;
#(
    parameter int unsigned N = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                inc_i,
    input  logic                clr_i,
    output logic [clog2(N)-1:0] cnt_o,
    output logic                last_o
);

    localparam int unsigned CNT_W = clog2(N);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: clear wins, otherwise increment with wrap at N-1.
    // NOTE: every signal written in always_comb gets a default at the top, so no path can leave it unassigned and infer a latch.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i) begin
            cnt_d = last_o ? '0 : cnt_q + CNT_W'(1);
        end
    end

    // Count register with asynchronous reset.
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o  = cnt_q;
    assign last_o = (cnt_q == CNT_W'(N - 1));

endmodule : sample_counter

// File: rtl/sum_accumulator.sv
// Block accumulator fed by the registered adder tree. Sums N accepted
// samples and offers the total on a valid/ready handshake. The tree cannot
// be stalled, so a sample arriving while a total is still unclaimed is
// dropped and recorded in the sticky overrun flag.
// Optional feature: define ACCUM_AVERAGE_EN to add the out_avg port
// (block total divided by N, truncating; N must be a power of two).
module sum_accumulator
    import accum_pkg::*;
#(
    parameter int unsigned W = 6,
    parameter int unsigned N = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear,
    input  logic                     in_valid,
    input  logic [W-1:0]             in_data,
    output logic                     in_ready,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [W+clog2(N)-1:0]    out_data,
`ifdef ACCUM_AVERAGE_EN
    output logic [W-1:0]             out_avg,
`endif
    output logic                     overrun
);

    localparam int unsigned LOG2N = clog2(N);
    localparam int unsigned ACC_W = W + LOG2N;

    if (N < 2) begin : g_bad_n
        $error("sum_accumulator: N must be at least 2");
    end

`ifdef ACCUM_AVERAGE_EN
    if ((N & (N - 1)) != 0) begin : g_bad_avg_n
        $error("sum_accumulator: N must be a power of two when averaging");
    end
`endif

    state_e            state_q, state_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [ACC_W-1:0]  out_data_q, out_data_d;
    logic              out_valid_q, out_valid_d;
    logic              overrun_q, overrun_d;
    logic              accept;
    logic              cnt_last;
    logic [LOG2N-1:0]  cnt;
    logic [ACC_W-1:0]  block_sum;

    // A new sample can be taken while collecting, or while holding if the
    // held total is being consumed in the same cycle.
    assign in_ready  = (state_q == ACCUM) || out_ready;
    assign accept    = in_valid && in_ready;
    assign block_sum = acc_q + ACC_W'(in_data);

    sample_counter #(
        .N      (N)
    ) u_sample_counter (
        .clk    (clk),
        .rst    (rst),
        .inc_i  (accept && !clear),
        .clr_i  (clear),
        .cnt_o  (cnt),
        .last_o (cnt_last)
    );

    // Next-state logic for the FSM, accumulator and output registers.
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        overrun_d   = overrun_q;

        if (clear) begin
            // Abort: the sample in this cycle is ignored; out_data keeps
            // the last completed total.
            state_d     = ACCUM;
            acc_d       = '0;
            out_valid_d = 1'b0;
            overrun_d   = 1'b0;
        end else begin
            if (in_valid && !in_ready) begin
                overrun_d = 1'b1;
            end

            unique case (state_q)
                ACCUM: begin
                    if (accept) begin
                        if (cnt_last) begin
                            out_data_d  = block_sum;
                            out_valid_d = 1'b1;
                            acc_d       = '0;
                            state_d     = HOLD;
                        end else begin
                            acc_d = block_sum;
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid_d = 1'b0;
                        state_d     = ACCUM;
                        // A sample accepted alongside the handshake starts
                        // the next block.
                        if (accept) begin
                            acc_d = ACC_W'(in_data);
                        end
                    end
                end
                default: begin
                    state_d = ACCUM;
                end
            endcase
        end
    end

    // State, accumulator and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ACCUM;
            acc_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            overrun_q   <= overrun_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign overrun   = overrun_q;

`ifdef ACCUM_AVERAGE_EN
    logic [W-1:0] avg_q;
    logic [W-1:0] avg_d;

    // Average is captured in the same cycle as the block total.
    always_comb begin
        avg_d = avg_q;
        if (!clear && state_q == ACCUM && accept && cnt_last) begin
            avg_d = W'(block_sum >> LOG2N);
        end
    end

    // Average register, updated alongside out_data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            avg_q <= '0;
        end else begin
            avg_q <= avg_d;
        end
    end

    assign out_avg = avg_q;
`endif

endmodule : sum_accumulator

// File: tb/tb_sum_accumulator.sv
// Directed self-checking bench for sum_accumulator (W=6, N=4).
// Define ACCUM_AVERAGE_EN for both bench and RTL to exercise out_avg.
module tb_sum_accumulator;

    logic       clk;
    logic       rst;
    logic       clear;
    logic       in_valid;
    logic [5:0] in_data;
    logic       in_ready;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
`ifdef ACCUM_AVERAGE_EN
    logic [5:0] out_avg;
`endif
    logic       overrun;

    int n_checks = 0;
    int n_fails  = 0;

    sum_accumulator #(
        .W (6),
        .N (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
`ifdef ACCUM_AVERAGE_EN
        .out_avg   (out_avg),
`endif
        .overrun   (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present one sample for exactly one clock edge; returns 1 time unit
    // after that edge with in_valid low.
    task automatic send(input logic [5:0] d);
        in_valid = 1'b1;
        in_data  = d;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic idle_cycle();
        @(posedge clk);
        #1;
    endtask

    // Async reset between clock edges takes effect immediately.
    task automatic test_reset();
        out_ready = 1'b0;
        #1 rst = 1'b1;
        #1;
        n_checks++; if (out_valid !== 1'b0) begin n_fails++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        n_checks++; if (out_data !== 8'd0) begin n_fails++; $display("FAIL reset_out_data: got %0d expected 0", out_data); end
        n_checks++; if (overrun !== 1'b0) begin n_fails++; $display("FAIL reset_overrun: got %b expected 0", overrun); end
        n_checks++; if (in_ready !== 1'b1) begin n_fails++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
`ifdef ACCUM_AVERAGE_EN
        n_checks++; if (out_avg !== 6'd0) begin n_fails++; $display("FAIL reset_out_avg: got %0d expected 0", out_avg); end
`endif
        #1 rst = 1'b0;
    endtask

    // 10,20,30,40 back to back -> 100, out_valid high for one cycle.
    task automatic test_basic_block();
        logic [5:0] v [4];
        v[0] = 6'd10; v[1] = 6'd20; v[2] = 6'd30; v[3] = 6'd40;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            send(v[i]);
            if (i < 3) begin
                n_checks++; if (out_valid !== 1'b0) begin n_fails++; $display("FAIL basic_early_valid[%0d]: got %b expected 0", i, out_valid); end
            end
        end
        n_checks++; if (out_valid !== 1'b1) begin n_fails++; $display("FAIL basic_valid: got %b expected 1", out_valid); end
        n_checks++; if (out_data !== 8'd100) begin n_fails++; $display("FAIL basic_data: got %0d expected 100", out_data); end
        idle_cycle();
        n_checks++; if (out_valid !== 1'b0) begin n_fails++; $display("FAIL basic_valid_one_cycle: got %b expected 0", out_valid); end
        n_checks++; if (out_data !== 8'd100) begin n_fails++; $display("FAIL basic_data_hold: got %0d expected 100", out_data); end
    endtask

    // Four maximal samples with idle gaps -> 252, no wrap in 8 bits.
    task automatic test_max_with_gaps();
        int gaps [4];
        gaps[0] = 2; gaps[1] = 0; gaps[2] = 3; gaps[3] = 1;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            for (int g = 0; g < gaps[i]; g++) idle_cycle();
            send(6'd63);
        end
        n_checks++; if (out_valid !== 1'b1) begin n_fails++; $display("FAIL max_valid: got %b expected 1", out_valid); end
        n_checks++; if (out_data !== 8'd252) begin n_fails++; $display("FAIL max_data: got %0d expected 252", out_data); end
        idle_cycle();
    endtask

    // Held total, dropped sample, then handshake with a sample that
    // starts the next block (5+6+7+8 = 26).
    task automatic test_backpressure_drop();
        out_ready = 1'b0;
        send(6'd10); send(6'd20); send(6'd30); send(6'd40);
        n_checks++; if (out_data !== 8'd100 || out_valid !== 1'b1) begin n_fails++; $display("FAIL bp_total: got data %0d valid %b expected 100/1", out_data, out_valid); end
        n_checks++; if (in_ready !== 1'b0) begin n_fails++; $display("FAIL bp_in_ready_low: got %b expected 0", in_ready); end
        n_checks++; if (overrun !== 1'b0) begin n_fails++; $display("FAIL bp_no_overrun_yet: got %b expected 0", overrun); end
        send(6'd7);
        n_checks++; if (overrun !== 1'b1) begin n_fails++; $display("FAIL bp_overrun: got %b expected 1", overrun); end
        n_checks++; if (out_data !== 8'd100 || out_valid !== 1'b1) begin n_fails++; $display("FAIL bp_hold_stable: got data %0d valid %b expected 100/1", out_data, out_valid); end
        out_ready = 1'b1;
        #1;
        n_checks++; if (in_ready !== 1'b1) begin n_fails++; $display("FAIL bp_in_ready_handshake: got %b expected 1", in_ready); end
        send(6'd5);
        n_checks++; if (out_valid !== 1'b0) begin n_fails++; $display("FAIL bp_handshake_valid: got %b expected 0", out_valid); end
        send(6'd6); send(6'd7);
        n_checks++; if (out_valid !== 1'b0) begin n_fails++; $display("FAIL bp_next_early: got %b expected 0", out_valid); end
        send(6'd8);
        n_checks++; if (out_valid !== 1'b1 || out_data !== 8'd26) begin n_fails++; $display("FAIL bp_next_block: got data %0d valid %b expected 26/1", out_data, out_valid); end
        n_checks++; if (overrun !== 1'b1) begin n_fails++; $display("FAIL bp_overrun_sticky: got %b expected 1", overrun); end
        idle_cycle();
    endtask

    // Reset mid-block clears the partial sum and the sticky flag at once.
    task automatic test_reset_midblock();
        out_ready = 1'b1;
        send(6'd9); send(6'd9);
        #1 rst = 1'b1;
        #1;
        n_checks++; if (overrun !== 1'b0 || out_data !== 8'd0 || out_valid !== 1'b0) begin n_fails++; $display("FAIL midreset_state: got ovr %b data %0d valid %b expected 0/0/0", overrun, out_data, out_valid); end
        #1 rst = 1'b0;
        send(6'd1); send(6'd2); send(6'd3);
        n_checks++; if (out_valid !== 1'b0) begin n_fails++; $display("FAIL midreset_early: got %b expected 0", out_valid); end
        send(6'd4);
        n_checks++; if (out_valid !== 1'b1 || out_data !== 8'd10) begin n_fails++; $display("FAIL midreset_block: got data %0d valid %b expected 10/1", out_data, out_valid); end
        idle_cycle();
    endtask

    // clear aborts a partial block, discards that cycle's sample, clears
    // overrun and keeps out_data.
    task automatic test_clear_restart();
        out_ready = 1'b0;
        send(6'd1); send(6'd1); send(6'd1); send(6'd1);
        send(6'd3);
        n_checks++; if (overrun !== 1'b1 || out_data !== 8'd4) begin n_fails++; $display("FAIL clr_setup: got ovr %b data %0d expected 1/4", overrun, out_data); end
        out_ready = 1'b1;
        send(6'd50); send(6'd60);
        clear    = 1'b1;
        in_valid = 1'b1;
        in_data  = 6'd33;
        @(posedge clk);
        #1;
        clear    = 1'b0;
        in_valid = 1'b0;
        n_checks++; if (overrun !== 1'b0) begin n_fails++; $display("FAIL clr_overrun: got %b expected 0", overrun); end
        n_checks++; if (out_valid !== 1'b0) begin n_fails++; $display("FAIL clr_valid: got %b expected 0", out_valid); end
        n_checks++; if (out_data !== 8'd4) begin n_fails++; $display("FAIL clr_data_kept: got %0d expected 4", out_data); end
        send(6'd1); send(6'd2); send(6'd3);
        n_checks++; if (out_valid !== 1'b0) begin n_fails++; $display("FAIL clr_early: got %b expected 0", out_valid); end
        send(6'd4);
        n_checks++; if (out_valid !== 1'b1 || out_data !== 8'd10) begin n_fails++; $display("FAIL clr_block: got data %0d valid %b expected 10/1", out_data, out_valid); end
        idle_cycle();
    endtask

`ifdef ACCUM_AVERAGE_EN
    // Average output: 100/4 = 25, 5/4 truncates to 1.
    task automatic test_average();
        out_ready = 1'b1;
        send(6'd10); send(6'd20); send(6'd30); send(6'd40);
        n_checks++; if (out_data !== 8'd100 || out_avg !== 6'd25) begin n_fails++; $display("FAIL avg_25: got data %0d avg %0d expected 100/25", out_data, out_avg); end
        idle_cycle();
        send(6'd1); send(6'd1); send(6'd1); send(6'd2);
        n_checks++; if (out_data !== 8'd5 || out_avg !== 6'd1) begin n_fails++; $display("FAIL avg_trunc: got data %0d avg %0d expected 5/1", out_data, out_avg); end
        idle_cycle();
    endtask
`endif

    initial begin
        rst       = 1'b0;
        clear     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;

        test_reset();
        test_basic_block();
        test_max_with_gaps();
        test_backpressure_drop();
        test_reset_midblock();
        test_clear_restart();
`ifdef ACCUM_AVERAGE_EN
        test_average();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule : tb_sum_accumulator
